// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with registered single-cycle results and an iterative multu/divu unit with HI/LO.
// Optional signed add/sub with overflow detect: define ALU_OVERFLOW_EN.
module alu_exec_unit #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         alu_op,
  input  logic [5:0]         funct,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  result,
  output logic               zero,
  output logic               out_valid,
  output logic               busy,
  output logic               illegal,
  output logic               ovf
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t              state;
  logic [DATA_W-1:0]   hi;
  logic [DATA_W-1:0]   lo;
  logic [DATA_W-1:0]   work_hi;
  logic [DATA_W-1:0]   work_lo;
  logic [DATA_W-1:0]   opnd;
  logic [SHAMT_W-1:0]  count;

  logic [DATA_W-1:0]   sum;
  logic [DATA_W-1:0]   diff;
  logic [DATA_W-1:0]   res;
  logic                ill;
  logic                sov;
  logic                start_mul;
  logic                start_div;

  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W:0]     div_trial;
  logic                div_fits;
  logic [DATA_W-1:0]   iter_hi;
  logic [DATA_W-1:0]   iter_lo;

  assign in_ready = ~busy;
  assign sum      = a + b;
  assign diff     = a - b;

  always_comb begin
    res       = '0;
    ill       = 1'b0;
    sov       = 1'b0;
    start_mul = 1'b0;
    start_div = 1'b0;
    case (alu_op)
      3'b001: res = sum;
      3'b010: res = a & b;
      3'b011: res = a | b;
      3'b100: res = a ^ b;
      3'b101: res = b << shamt;
      3'b110: res = DATA_W'($signed(a) < $signed(b));
      3'b111: res = b << (DATA_W / 2);
      default: begin
        case (funct)
          6'b000000: res = b << shamt;
          6'b000010: res = b >> shamt;
          6'b000011: res = $signed(b) >>> shamt;
          6'b000100: res = b << a[SHAMT_W-1:0];
          6'b000110: res = b >> a[SHAMT_W-1:0];
          6'b000111: res = $signed(b) >>> a[SHAMT_W-1:0];
          6'b100001: res = sum;
          6'b100011: res = diff;
          6'b100100: res = a & b;
          6'b100101: res = a | b;
          6'b100110: res = a ^ b;
          6'b100111: res = ~(a | b);
          6'b101010: res = DATA_W'($signed(a) < $signed(b));
          6'b101011: res = DATA_W'(a < b);
          6'b001001: res = sum;
          6'b010000: res = hi;
          6'b010010: res = lo;
          6'b011001: start_mul = 1'b1;
          6'b011011: start_div = 1'b1;
`ifdef ALU_OVERFLOW_EN
          6'b100000: begin
            res = sum;
            sov = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
          end
          6'b100010: begin
            res = diff;
            sov = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
          end
`else
          6'b100000: res = sum;
          6'b100010: res = diff;
`endif
          default: ill = 1'b1;
        endcase
      end
    endcase
  end

  // Shift-add: product accumulates in work_hi while the multiplier drains out of work_lo.
  assign mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);

  // Restoring division: partial remainder stays below the divisor, so it fits in work_hi.
  assign div_shift = {work_hi, work_lo[DATA_W-1]};
  assign div_trial = div_shift - {1'b0, opnd};
  assign div_fits  = ~div_trial[DATA_W];

  always_comb begin
    if (state == MUL) begin
      iter_hi = mul_sum[DATA_W:1];
      iter_lo = {mul_sum[0], work_lo[DATA_W-1:1]};
    end else begin
      iter_hi = div_fits ? div_trial[DATA_W-1:0] : div_shift[DATA_W-1:0];
      iter_lo = {work_lo[DATA_W-2:0], div_fits};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hi        <= '0;
      lo        <= '0;
      work_hi   <= '0;
      work_lo   <= '0;
      opnd      <= '0;
      count     <= '0;
      result    <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      ovf       <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (in_valid) begin
            if (start_mul || start_div) begin
              state   <= start_mul ? MUL : DIV;
              busy    <= 1'b1;
              count   <= '0;
              work_hi <= '0;
              opnd    <= start_mul ? a : b;
              work_lo <= start_mul ? b : a;
            end else begin
              result    <= res;
              zero      <= (res == '0);
              out_valid <= 1'b1;
              illegal   <= ill;
              ovf       <= sov;
            end
          end
        end
        default: begin
          work_hi <= iter_hi;
          work_lo <= iter_lo;
          count   <= count + SHAMT_W'(1);
          if (count == SHAMT_W'(DATA_W - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            hi        <= iter_hi;
            lo        <= iter_lo;
            result    <= iter_lo;
            zero      <= (iter_lo == '0);
            out_valid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomised bench for alu_exec_unit against a cycle-scheduled arithmetic reference model.
module tb_alu_exec_unit;
  localparam int DW = 32;
  localparam int SW = 5;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    alu_op = '0;
  logic [5:0]    funct = '0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic [SW-1:0] shamt = '0;
  logic [DW-1:0] result;
  logic          zero;
  logic          out_valid;
  logic          busy;
  logic          illegal;
  logic          ovf;

  alu_exec_unit #(.DATA_W(DW), .SHAMT_W(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .a(a), .b(b), .shamt(shamt),
    .result(result), .zero(zero), .out_valid(out_valid), .busy(busy),
    .illegal(illegal), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct packed {
    logic [31:0] res;
    logic        ill;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[int];
  bit          rst_chk[int];
  int          busy_from = 1;
  int          busy_to = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          checks = 0;
  int          failures = 0;
  bit          running = 1'b0;

`ifdef ALU_OVERFLOW_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic [5:0] flist [22] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21, 6'h23,
                             6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h09, 6'h10,
                             6'h12, 6'h19, 6'h1B, 6'h20, 6'h22, 6'h3F};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Reference semantics written directly from the instruction definitions.
  task automatic ref_op(input logic [2:0] op, input logic [5:0] f,
                        input logic [31:0] ra, input logic [31:0] rb, input logic [4:0] sh,
                        input logic [31:0] hi_in, input logic [31:0] lo_in,
                        output logic [31:0] res, output logic ill, output logic ovfo,
                        output bit long_op, output logic [31:0] hi_out, output logic [31:0] lo_out);
    logic [63:0] p;
`ifdef ALU_OVERFLOW_EN
    longint s;
`endif
    res = '0; ill = 1'b0; ovfo = 1'b0; long_op = 1'b0; hi_out = hi_in; lo_out = lo_in;
    case (op)
      3'd1: res = ra + rb;
      3'd2: res = ra & rb;
      3'd3: res = ra | rb;
      3'd4: res = ra ^ rb;
      3'd5: res = rb << sh;
      3'd6: res = ($signed(ra) < $signed(rb)) ? 32'd1 : 32'd0;
      3'd7: res = rb * 32'd65536;
      default: begin
        case (f)
          6'h00: res = rb << sh;
          6'h02: res = rb >> sh;
          6'h03: res = 32'($signed(rb) >>> sh);
          6'h04: res = rb << ra[4:0];
          6'h06: res = rb >> ra[4:0];
          6'h07: res = 32'($signed(rb) >>> ra[4:0]);
          6'h21, 6'h09: res = ra + rb;
          6'h23: res = ra - rb;
          6'h24: res = ra & rb;
          6'h25: res = ra | rb;
          6'h26: res = ra ^ rb;
          6'h27: res = ~(ra | rb);
          6'h2A: res = ($signed(ra) < $signed(rb)) ? 32'd1 : 32'd0;
          6'h2B: res = (ra < rb) ? 32'd1 : 32'd0;
          6'h10: res = hi_in;
          6'h12: res = lo_in;
          6'h19: begin
            long_op = 1'b1;
            p = 64'(ra) * 64'(rb);
            hi_out = p[63:32];
            lo_out = p[31:0];
            res = lo_out;
          end
          6'h1B: begin
            long_op = 1'b1;
            if (rb == 0) begin
              hi_out = ra;
              lo_out = '1;
            end else begin
              lo_out = ra / rb;
              hi_out = ra % rb;
            end
            res = lo_out;
          end
          6'h20: begin
            res = ra + rb;
`ifdef ALU_OVERFLOW_EN
            s = longint'($signed(ra)) + longint'($signed(rb));
            ovfo = (s > SMAX) || (s < SMIN);
`endif
          end
          6'h22: begin
            res = ra - rb;
`ifdef ALU_OVERFLOW_EN
            s = longint'($signed(ra)) - longint'($signed(rb));
            ovfo = (s > SMAX) || (s < SMIN);
`endif
          end
          default: ill = 1'b1;
        endcase
      end
    endcase
  endtask

  // Schedules the expected outputs for whatever the inputs present in cycle c.
  task automatic model_step(input int c);
    logic [31:0] r, nh, nl;
    logic        il, ov;
    bit          lg, ready;
    if (rst) begin
      m_hi = '0;
      m_lo = '0;
      if (busy_to > c) busy_to = c;
      for (int k = c + 1; k <= c + DW + 2; k++)
        if (exp_q.exists(k)) exp_q.delete(k);
      rst_chk[c + 1] = 1'b1;
      return;
    end
    ready = !(c >= busy_from && c <= busy_to);
    if (!(in_valid && ready)) return;
    ref_op(alu_op, funct, a, b, shamt, m_hi, m_lo, r, il, ov, lg, nh, nl);
    if (lg) begin
      m_hi = nh;
      m_lo = nl;
      busy_from = c + 1;
      busy_to = c + DW;
      exp_q[c + DW + 1] = exp_t'{r, 1'b0, 1'b0};
    end else begin
      exp_q[c + 1] = exp_t'{r, il, ov};
    end
  endtask

  task automatic drive(input bit r, input bit v, input logic [2:0] op, input logic [5:0] f,
                       input logic [31:0] ra, input logic [31:0] rb, input logic [4:0] sh);
    rst = r; in_valid = v; alu_op = op; funct = f; a = ra; b = rb; shamt = sh;
    model_step(cyc);
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] o, input logic [5:0] f, input logic [31:0] ra,
                    input logic [31:0] rb, input logic [4:0] sh);
    drive(1'b0, 1'b1, o, f, ra, rb, sh);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'd1, 6'h21, $urandom, $urandom, 5'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (running) begin
      bit eb, ev;
      exp_t e;
      eb = (cyc >= busy_from && cyc <= busy_to);
      chk("busy", 64'(busy), 64'(eb));
      chk("in_ready", 64'(in_ready), 64'(!eb));
      ev = exp_q.exists(cyc);
      chk("out_valid", 64'(out_valid), 64'(ev));
      if (ev) begin
        e = exp_q[cyc];
        chk("result", 64'(result), 64'(e.res));
        chk("zero", 64'(zero), 64'(e.res == 0));
        chk("illegal", 64'(illegal), 64'(e.ill));
        chk("ovf", 64'(ovf), 64'(e.ovf));
        exp_q.delete(cyc);
      end else begin
        chk("illegal_idle", 64'(illegal), 64'd0);
        chk("ovf_idle", 64'(ovf), 64'd0);
      end
      if (rst_chk.exists(cyc)) begin
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_zero", 64'(zero), 64'd1);
        rst_chk.delete(cyc);
      end
    end
  end

  initial begin
    logic [31:0] r, nh, nl;
    logic        il, ov;
    bit          lg;
    logic [2:0]  o;
    logic [5:0]  f;

    // Pin the reference model to hand-computed values.
    ref_op(3'd0, 6'h21, 32'h7FFF_FFFF, 32'd1, 5'd0, 0, 0, r, il, ov, lg, nh, nl);
    chk("model_addu", 64'(r), 64'h8000_0000);
    ref_op(3'd0, 6'h03, 32'd0, 32'hF000_0000, 5'd4, 0, 0, r, il, ov, lg, nh, nl);
    chk("model_sra", 64'(r), 64'hFF00_0000);
    ref_op(3'd0, 6'h06, 32'd4, 32'hF000_0000, 5'd0, 0, 0, r, il, ov, lg, nh, nl);
    chk("model_srlv", 64'(r), 64'h0F00_0000);
    ref_op(3'd7, 6'h00, 32'd0, 32'h1234, 5'd0, 0, 0, r, il, ov, lg, nh, nl);
    chk("model_lui", 64'(r), 64'h1234_0000);
    ref_op(3'd0, 6'h19, 32'hFFFF_FFFF, 32'd2, 5'd0, 0, 0, r, il, ov, lg, nh, nl);
    chk("model_multu", {nh, nl}, 64'h1_FFFF_FFFE);
    ref_op(3'd0, 6'h1B, 32'd7, 32'd0, 5'd0, 0, 0, r, il, ov, lg, nh, nl);
    chk("model_divu0", {nh, nl}, 64'h7_FFFF_FFFF);
    ref_op(3'd0, 6'h1B, 32'd100, 32'd7, 5'd0, 0, 0, r, il, ov, lg, nh, nl);
    chk("model_divu", {nh, nl}, {32'd2, 32'd14});
    ref_op(3'd0, 6'h20, 32'h7FFF_FFFF, 32'd1, 5'd0, 0, 0, r, il, ov, lg, nh, nl);
    chk("model_add_ovf", 64'(ov), 64'(OVF_ON));

    running = 1'b1;
    drive(1'b1, 1'b0, 3'd0, 6'h0, 0, 0, 0);
    drive(1'b1, 1'b0, 3'd0, 6'h0, 0, 0, 0);

    op(3'd1, 6'h00, 32'h7FFF_FFFF, 32'd1, 5'd0);
    chk("dir_add_res", 64'(result), 64'h8000_0000);
    chk("dir_add_ovf", 64'(ovf), 64'd0);
    op(3'd0, 6'h03, 32'd0, 32'hF000_0000, 5'd4);
    chk("dir_sra", 64'(result), 64'hFF00_0000);
    op(3'd0, 6'h06, 32'd4, 32'hF000_0000, 5'd0);
    chk("dir_srlv", 64'(result), 64'h0F00_0000);
    op(3'd7, 6'h00, 32'd0, 32'h1234, 5'd0);
    chk("dir_lui", 64'(result), 64'h1234_0000);

    op(3'd0, 6'h19, 32'hFFFF_FFFF, 32'd2, 5'd0);
    for (int i = 0; i < DW; i++) op(3'd1, 6'h00, $urandom, $urandom, 5'd0);
    chk("dir_multu_valid", 64'(out_valid), 64'd1);
    chk("dir_multu_lo", 64'(result), 64'hFFFF_FFFE);
    op(3'd0, 6'h10, 0, 0, 0);
    chk("dir_mfhi_mul", 64'(result), 64'd1);

    op(3'd0, 6'h1B, 32'd7, 32'd0, 5'd0);
    idle(DW);
    chk("dir_divu0_lo", 64'(result), 64'hFFFF_FFFF);
    op(3'd0, 6'h10, 0, 0, 0);
    chk("dir_divu0_hi", 64'(result), 64'd7);
    op(3'd0, 6'h1B, 32'd100, 32'd7, 5'd0);
    idle(DW);
    chk("dir_divu_lo", 64'(result), 64'd14);
    op(3'd0, 6'h10, 0, 0, 0);
    chk("dir_divu_hi", 64'(result), 64'd2);

    op(3'd0, 6'h1B, 32'd100, 32'd7, 5'd0);
    idle(9);
    drive(1'b1, 1'b0, 3'd0, 6'h0, 0, 0, 0);
    chk("dir_rst_busy", 64'(busy), 64'd0);
    chk("dir_rst_ready", 64'(in_ready), 64'd1);
    chk("dir_rst_valid", 64'(out_valid), 64'd0);
    op(3'd0, 6'h10, 0, 0, 0);
    chk("dir_rst_mfhi", 64'(result), 64'd0);

    op(3'd0, 6'h3F, 32'd5, 32'd6, 5'd0);
    chk("dir_illegal", 64'(illegal), 64'd1);
    chk("dir_illegal_res", 64'(result), 64'd0);
    op(3'd0, 6'h20, 32'h7FFF_FFFF, 32'd1, 5'd0);
    chk("dir_add20_ovf", 64'(ovf), 64'(OVF_ON));
    chk("dir_add20_res", 64'(result), 64'h8000_0000);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        drive(1'b1, 1'b0, 3'd0, 6'h0, 0, 0, 0);
      end else begin
        o = 3'($urandom_range(0, 7));
        if (o != 0 && $urandom_range(0, 2) == 0) o = 3'd0;
        f = ($urandom_range(0, 9) == 0) ? 6'($urandom) : flist[$urandom_range(0, 21)];
        drive(1'b0, $urandom_range(0, 4) != 0, o, f, pick(), pick(), 5'($urandom));
      end
    end
    idle(DW + 3);
    running = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised execute-stage ALU for the MIPS datapath.
- Decodes alu_op and funct internally, registers single-cycle results, and adds an iterative unsigned multiply/divide unit with HI/LO registers.
- Sits between ID/EX and EX/MEM; the pipeline stalls on in_ready low.

Parameters:
DATA_W, 32, operand/result width; must be even and ≥8
SHAMT_W, 5, shift-amount width; must equal clog2(DATA_W)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operation presented
in_ready  out  1  unit can accept; equals ~busy
alu_op  in  3  main-control ALU class
funct  in  6  R-type funct field
a  in  DATA_W  rs operand
b  in  DATA_W  rt / immediate operand
shamt  in  SHAMT_W  instruction shift amount
result  out  DATA_W  registered result
zero  out  1  result == 0, registered with result
out_valid  out  1  one-cycle pulse, result valid
busy  out  1  mult/div in progress
illegal  out  1  one-cycle pulse: unknown R-type funct accepted
ovf  out  1  signed overflow (see Optional Feature)

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: result=0, zero=1, out_valid=0, illegal=0, ovf=0, busy=0, HI=LO=0, FSM=IDLE.
- Accept when in_valid & in_ready.
- alu_op decode:
  - 001 add
  - 010 and
  - 011 or
  - 100 xor
  - 101 sll b by shamt
  - 110 slt signed
  - 111 lui: b << DATA_W/2
  - 000 R-type by funct
- R-type funct decode:
  - Immediate shifts, amount = shamt: 000000 sll, 000010 srl, 000011 sra.
  - Variable shifts, amount = a[SHAMT_W-1:0]: 000100 sllv, 000110 srlv, 000111 srav.
  - Arithmetic/logic: 100001 addu, 100011 subu, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt (signed), 101011 sltu.
  - Other: 001001 jalr = a+b, 010000 mfhi, 010010 mflo, 011001 multu, 011011 divu.
- Shifts always operate on b. Arithmetic is modulo 2^DATA_W. slt/sltu produce 0 or 1, zero-extended.
- Unknown funct: result=0, out_valid=1, illegal=1 in the same cycle.
- Single-cycle ops: result, zero and out_valid update on the edge after acceptance (latency 1). out_valid is low on every other cycle.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE → MUL or DIV on an accepted multu/divu; busy=1 from the next cycle.
  - MUL: shift-add, one bit per cycle, DATA_W cycles, 2*DATA_W-bit product.
  - DIV: restoring division, one quotient bit per cycle, DATA_W cycles.
  - Either → DONE after DATA_W iterations; HI/LO are written on entry to DONE.
  - DONE → IDLE next cycle. In DONE: out_valid=1, result=LO, busy=0.
  - Total: out_valid exactly DATA_W+1 cycles after acceptance.
- multu: HI = upper half, LO = lower half.
- divu: LO = quotient, HI = remainder.
- divu by zero: HI = a, LO = all ones; normal timing, no flag.
- While busy: in_ready=0, inputs ignored, no decode side-effects. mfhi/mflo are therefore never observed mid-operation.
- Operands are latched at acceptance; later changes on a/b do not affect the running operation.
- rst asserted mid-operation aborts the operation: next cycle FSM=IDLE, busy=0, HI=LO=0, no out_valid.
- Back-to-back single-cycle ops: accepted every cycle, out_valid continuously high.

Optional Feature:
- Macro: ALU_OVERFLOW_EN.
- Defined:
  - Funct 100000 (add) and 100010 (sub) are decoded as signed ops; alu_op 001 remains a non-trapping add.
  - ovf pulses with out_valid when the signed result overflows: same-sign operands giving opposite-sign sum, or the sub equivalent.
  - On ovf, result still holds the wrapped value.
- Undefined:
  - 100000/100010 decode as addu/subu; ovf is tied to 0.

Test Plan:
- addu a=0x7FFFFFFF, b=1 → next cycle result=0x80000000, zero=0, out_valid=1, ovf=0.
- sra b=0xF0000000, shamt=4 → 0xFF000000; srlv a=4, b=0xF0000000 → 0x0F000000; lui b=0x1234 → 0x12340000.
- multu a=0xFFFFFFFF, b=2 → busy for 32 cycles, out_valid at cycle 33 with result=0xFFFFFFFE; then mfhi → 0x00000001. An in_valid pulse during busy is ignored.
- divu a=7, b=0 → HI=7, LO=0xFFFFFFFF. divu a=100, b=7 → LO=14, HI=2.
- Start divu; assert rst at cycle 10 → busy=0, in_ready=1 next cycle, no out_valid; mfhi → 0.
- ALU_OVERFLOW_EN defined: add a=0x7FFFFFFF, b=1 → ovf=1, result=0x80000000. Undefined: same stimulus → ovf=0. Unknown funct 111111 in both builds → illegal=1, result=0.
